// File: rtl/riscv_pkg.sv
// Shared RV32I encodings used by the pipeline control blocks: opcodes, branch
// funct3 values and the PC-mux select encoding.
package riscv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;
    localparam logic [2:0] F3_BGE = 3'b101;

    localparam logic [1:0] PCSEL_NONE = 2'b00;
    localparam logic [1:0] PCSEL_TGT  = 2'b01;
    localparam logic [1:0] PCSEL_SEQ  = 2'b10;
    localparam logic [1:0] PCSEL_ALU  = 2'b11;

    typedef struct packed {
        logic is_cond;
        logic taken;
    } cond_eval_t;

    // Non-branch funct3 encodings report is_cond = 0 so they neither redirect nor train.
    function automatic cond_eval_t cond_eval(input logic [2:0] funct3,
                                             input logic breq, input logic brlt);
        cond_eval_t r;
        r = '0;
        case (funct3)
            F3_BEQ: r = '{is_cond: 1'b1, taken: breq};
            F3_BNE: r = '{is_cond: 1'b1, taken: !breq};
            F3_BLT: r = '{is_cond: 1'b1, taken: brlt};
            F3_BGE: r = '{is_cond: 1'b1, taken: !brlt};
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/bht_table.sv
// Branch history table: saturating counters with one combinational read port
// and one saturating update port; synchronous reset to weakly not-taken.
module bht_table #(
    parameter int ENTRIES  = 64,
    parameter int CTR_BITS = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [$clog2(ENTRIES)-1:0]  rd_idx,
    output logic [CTR_BITS-1:0]         rd_ctr,
    input  logic                        upd_en,
    input  logic [$clog2(ENTRIES)-1:0]  upd_idx,
    input  logic                        upd_taken
);

    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    localparam logic [CTR_BITS-1:0] CTR_ONE  = CTR_BITS'(1);

    logic [CTR_BITS-1:0] ctr [ENTRIES];

    // Read sees the pre-update value when the same entry is written this cycle.
    assign rd_ctr = ctr[rd_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr[i] <= CTR_INIT;
            end
        end else if (upd_en) begin
            if (upd_taken) begin
                if (ctr[upd_idx] != CTR_MAX) ctr[upd_idx] <= ctr[upd_idx] + CTR_ONE;
            end else begin
                if (ctr[upd_idx] != '0) ctr[upd_idx] <= ctr[upd_idx] - CTR_ONE;
            end
        end
    end

endmodule

// File: rtl/branch_predict_ctrl.sv
// Branch prediction (IF) and resolution (EX) controller: BHT lookup, redirect
// decode, multi-cycle flush down-counter and branch/mispredict statistics.
module branch_predict_ctrl
    import riscv_pkg::*;
#(
    parameter int MODE         = 1,
    parameter int BHT_ENTRIES  = 64,
    parameter int CTR_BITS     = 2,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       if_pc,
    input  logic              if_is_cbranch,
    output logic              if_pred_taken,
    input  logic              ex_valid,
    input  logic [6:0]        ex_opcode,
    input  logic [2:0]        ex_funct3,
    input  logic              ex_breq,
    input  logic              ex_brlt,
    input  logic [31:0]       ex_pc,
    input  logic              ex_pred_taken,
    output logic              redirect,
    output logic [1:0]        redirect_sel,
    output logic              flush,
    input  logic              stat_clr,
    output logic [CNT_W-1:0]  br_count,
    output logic [CNT_W-1:0]  mispred_count
);

    localparam int                IDX_W   = $clog2(BHT_ENTRIES);
    localparam int                FC_W    = $clog2(FLUSH_CYCLES + 1);
    localparam logic [FC_W-1:0]   FC_LOAD = FC_W'(FLUSH_CYCLES - 1);
    localparam logic [FC_W-1:0]   FC_ONE  = FC_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

    logic [FC_W-1:0]     flush_cnt;
    logic [CTR_BITS-1:0] if_ctr;
    logic                ex_live;
    logic                mispredict;
    logic                cond_upd;
    cond_eval_t          ce;

    logic unused_pc_bits;
    assign unused_pc_bits = ^{if_pc[31:IDX_W+2], if_pc[1:0], ex_pc[31:IDX_W+2], ex_pc[1:0]};

    bht_table #(
        .ENTRIES  (BHT_ENTRIES),
        .CTR_BITS (CTR_BITS)
    ) u_bht (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (if_pc[IDX_W+1:2]),
        .rd_ctr    (if_ctr),
        .upd_en    (cond_upd && (MODE != 0)),
        .upd_idx   (ex_pc[IDX_W+1:2]),
        .upd_taken (ce.taken)
    );

    assign if_pred_taken = (MODE != 0) && if_is_cbranch && if_ctr[CTR_BITS-1];

    // Instructions in the flush shadow are wrong-path and must not act.
    assign ex_live  = ex_valid && (flush_cnt == '0);
    assign ce       = (ex_opcode == OP_BRANCH) ? cond_eval(ex_funct3, ex_breq, ex_brlt) : '0;
    assign cond_upd = ex_live && ce.is_cond;

    always_comb begin
        redirect     = 1'b0;
        redirect_sel = PCSEL_NONE;
        mispredict   = 1'b0;
        if (ex_live) begin
            if (ce.is_cond) begin
                if (ce.taken != ex_pred_taken) begin
                    redirect     = 1'b1;
                    redirect_sel = ce.taken ? PCSEL_TGT : PCSEL_SEQ;
                    mispredict   = 1'b1;
                end
            end else if (ex_opcode == OP_JAL) begin
                redirect     = 1'b1;
                redirect_sel = PCSEL_TGT;
            end else if (ex_opcode == OP_JALR) begin
                redirect     = 1'b1;
                redirect_sel = PCSEL_ALU;
            end
        end
    end

    assign flush = redirect || (flush_cnt != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            flush_cnt <= '0;
        end else if (redirect) begin
            flush_cnt <= FC_LOAD;
        end else if (flush_cnt != '0) begin
            flush_cnt <= flush_cnt - FC_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            br_count      <= '0;
            mispred_count <= '0;
        end else if (cond_upd) begin
            br_count <= br_count + CNT_ONE;
            if (mispredict) mispred_count <= mispred_count + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Scoreboard bench: two configurations share stimulus; a reference model pushes
// expected per-cycle outputs and a monitor pops and compares them.
module tb_branch_predict_ctrl;
    import riscv_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, if_is_cbranch, ex_valid, ex_breq, ex_brlt, ex_pred_taken, stat_clr;
    logic [31:0] if_pc, ex_pc;
    logic [6:0]  ex_opcode;
    logic [2:0]  ex_funct3;

    logic        a_pred, a_redir, a_flush;
    logic [1:0]  a_sel;
    logic [31:0] a_brc, a_mpc;
    logic        b_pred, b_redir, b_flush;
    logic [1:0]  b_sel;
    logic [3:0]  b_brc, b_mpc;

    branch_predict_ctrl #(.MODE(1), .BHT_ENTRIES(64), .CTR_BITS(2), .FLUSH_CYCLES(2), .CNT_W(32)) dut_a (
        .clk(clk), .rst(rst), .if_pc(if_pc), .if_is_cbranch(if_is_cbranch), .if_pred_taken(a_pred),
        .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_funct3(ex_funct3), .ex_breq(ex_breq),
        .ex_brlt(ex_brlt), .ex_pc(ex_pc), .ex_pred_taken(ex_pred_taken), .redirect(a_redir),
        .redirect_sel(a_sel), .flush(a_flush), .stat_clr(stat_clr), .br_count(a_brc),
        .mispred_count(a_mpc));

    branch_predict_ctrl #(.MODE(0), .BHT_ENTRIES(16), .CTR_BITS(3), .FLUSH_CYCLES(3), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .if_pc(if_pc), .if_is_cbranch(if_is_cbranch), .if_pred_taken(b_pred),
        .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_funct3(ex_funct3), .ex_breq(ex_breq),
        .ex_brlt(ex_brlt), .ex_pc(ex_pc), .ex_pred_taken(ex_pred_taken), .redirect(b_redir),
        .redirect_sel(b_sel), .flush(b_flush), .stat_clr(stat_clr), .br_count(b_brc),
        .mispred_count(b_mpc));

    typedef struct packed {
        logic        chk;
        logic        pred;
        logic        redir;
        logic [1:0]  sel;
        logic        flush;
        logic [31:0] brc;
        logic [31:0] mpc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int     p_mode [2] = '{1, 0};
    int     p_ent  [2] = '{64, 16};
    int     p_cb   [2] = '{2, 3};
    int     p_fc   [2] = '{2, 3};
    int     p_cw   [2] = '{32, 4};
    int     bht    [2][64];
    int     shadow [2];
    longint brc    [2];
    longint mpc    [2];

    int vectors = 0;
    int miscompares = 0;

    // Reference model: evaluates this cycle's outputs from the architectural rules,
    // then advances its own state to what it should be after the next edge.
    task automatic model_step(input int m, output exp_t e);
        int     idx, maxc;
        bit     is_br, tk, live, mis;
        longint wrap;
        e = '0;
        if (rst) begin
            for (int i = 0; i < 64; i++) bht[m][i] = (1 << (p_cb[m] - 1)) - 1;
            shadow[m] = 0;
            brc[m] = 0;
            mpc[m] = 0;
            return;
        end
        e.chk = 1'b1;
        is_br = 0;
        tk    = 0;
        if (ex_opcode == 7'h63) begin
            case (ex_funct3)
                3'd0: begin is_br = 1; tk = ex_breq;  end
                3'd1: begin is_br = 1; tk = !ex_breq; end
                3'd4: begin is_br = 1; tk = ex_brlt;  end
                3'd5: begin is_br = 1; tk = !ex_brlt; end
                default: is_br = 0;
            endcase
        end
        idx    = int'((if_pc >> 2) % p_ent[m]);
        e.pred = (p_mode[m] != 0) && if_is_cbranch && (bht[m][idx] >= (1 << (p_cb[m] - 1)));
        live   = ex_valid && (shadow[m] == 0);
        mis    = 0;
        if (live) begin
            if (is_br) begin
                if (tk != ex_pred_taken) begin
                    e.redir = 1'b1;
                    e.sel   = tk ? 2'd1 : 2'd2;
                    mis     = 1;
                end
            end else if (ex_opcode == 7'h6f) begin
                e.redir = 1'b1;
                e.sel   = 2'd1;
            end else if (ex_opcode == 7'h67) begin
                e.redir = 1'b1;
                e.sel   = 2'd3;
            end
        end
        e.flush = e.redir || (shadow[m] > 0);
        e.brc   = 32'(brc[m]);
        e.mpc   = 32'(mpc[m]);

        if (e.redir) shadow[m] = p_fc[m] - 1;
        else if (shadow[m] > 0) shadow[m] = shadow[m] - 1;
        if (live && is_br && (p_mode[m] != 0)) begin
            idx  = int'((ex_pc >> 2) % p_ent[m]);
            maxc = (1 << p_cb[m]) - 1;
            if (tk) bht[m][idx] = (bht[m][idx] < maxc) ? bht[m][idx] + 1 : maxc;
            else    bht[m][idx] = (bht[m][idx] > 0) ? bht[m][idx] - 1 : 0;
        end
        wrap = 64'd1 << p_cw[m];
        if (stat_clr) begin
            brc[m] = 0;
            mpc[m] = 0;
        end else if (live && is_br) begin
            brc[m] = (brc[m] + 1) % wrap;
            if (mis) mpc[m] = (mpc[m] + 1) % wrap;
        end
    endtask

    task automatic tick();
        exp_t e0, e1;
        model_step(0, e0);
        model_step(1, e1);
        q0.push_back(e0);
        q1.push_back(e1);
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        rst = 0; stat_clr = 0;
        if_pc = 0; if_is_cbranch = 0;
        ex_valid = 0; ex_opcode = 7'h13; ex_funct3 = 0;
        ex_breq = 0; ex_brlt = 0; ex_pc = 0; ex_pred_taken = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic ex_op(input logic [6:0] op, input logic [2:0] f3, input logic eq,
                         input logic lt, input logic [31:0] pc, input logic pr);
        ex_valid = 1; ex_opcode = op; ex_funct3 = f3;
        ex_breq = eq; ex_brlt = lt; ex_pc = pc; ex_pred_taken = pr;
        tick();
        ex_valid = 0; ex_opcode = 7'h13;
    endtask

    task automatic fetch(input logic [31:0] pc);
        if_pc = pc; if_is_cbranch = 1;
        tick();
        if_is_cbranch = 0;
    endtask

    task automatic compare(input int m, input exp_t e, input logic pred, input logic redir,
                           input logic [1:0] sel, input logic fl, input logic [31:0] bc,
                           input logic [31:0] mc);
        vectors++;
        if (pred !== e.pred) begin
            miscompares++;
            $display("FAIL dut%0d if_pred_taken t=%0t got %b exp %b", m, $time, pred, e.pred);
        end
        if (redir !== e.redir) begin
            miscompares++;
            $display("FAIL dut%0d redirect t=%0t got %b exp %b", m, $time, redir, e.redir);
        end
        if (sel !== e.sel) begin
            miscompares++;
            $display("FAIL dut%0d redirect_sel t=%0t got %b exp %b", m, $time, sel, e.sel);
        end
        if (fl !== e.flush) begin
            miscompares++;
            $display("FAIL dut%0d flush t=%0t got %b exp %b", m, $time, fl, e.flush);
        end
        if (bc !== e.brc) begin
            miscompares++;
            $display("FAIL dut%0d br_count t=%0t got %0d exp %0d", m, $time, bc, e.brc);
        end
        if (mc !== e.mpc) begin
            miscompares++;
            $display("FAIL dut%0d mispred_count t=%0t got %0d exp %0d", m, $time, mc, e.mpc);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q0.size() > 0) begin
                e = q0.pop_front();
                if (e.chk) compare(0, e, a_pred, a_redir, a_sel, a_flush, a_brc, a_mpc);
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                if (e.chk) compare(1, e, b_pred, b_redir, b_sel, b_flush, {28'd0, b_brc}, {28'd0, b_mpc});
            end
        end
    end

    initial begin : driver
        set_idle();
        rst = 1;
        @(posedge clk);
        #1;
        tick();
        rst = 0;

        fetch(32'h40);
        ex_op(OP_BRANCH, F3_BEQ, 1, 0, 32'h40, 0);
        idle(3);
        ex_op(OP_BRANCH, F3_BEQ, 1, 0, 32'h40, 1);
        idle(3);
        ex_op(OP_BRANCH, F3_BEQ, 1, 0, 32'h40, 1);
        idle(3);
        fetch(32'h40);
        ex_op(OP_BRANCH, F3_BNE, 1, 0, 32'h80, 1);
        idle(3);
        ex_op(OP_JALR, 3'd0, 0, 0, 32'h84, 0);
        ex_op(OP_BRANCH, F3_BGE, 0, 0, 32'h40, 0);
        idle(3);
        ex_op(OP_BRANCH, F3_BLT, 0, 1, 32'h90, 0);
        idle(3);
        fetch(32'h90);
        ex_op(OP_BRANCH, 3'd2, 1, 1, 32'h94, 0);
        stat_clr = 1;
        ex_op(OP_BRANCH, F3_BNE, 1, 0, 32'h98, 1);
        stat_clr = 0;
        idle(3);
        ex_op(OP_JAL, 3'd0, 0, 0, 32'h0, 0);
        rst = 1;
        tick();
        rst = 0;
        idle(2);
        for (int i = 0; i < 16; i++) ex_op(OP_BRANCH, F3_BNE, 0, 0, 32'h100, 1);
        idle(2);

        for (int i = 0; i < 3000; i++) begin
            rst           = ($urandom_range(0, 199) == 0);
            stat_clr      = ($urandom_range(0, 49) == 0);
            if_pc         = 32'($urandom_range(0, 255)) << 2;
            if_is_cbranch = 1'($urandom_range(0, 1));
            ex_valid      = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 5))
                0, 1, 2: ex_opcode = OP_BRANCH;
                3:       ex_opcode = OP_JAL;
                4:       ex_opcode = OP_JALR;
                default: ex_opcode = OP_OP;
            endcase
            ex_funct3     = 3'($urandom_range(0, 7));
            ex_breq       = 1'($urandom_range(0, 1));
            ex_brlt       = 1'($urandom_range(0, 1));
            ex_pc         = 32'($urandom_range(0, 255)) << 2;
            ex_pred_taken = 1'($urandom_range(0, 1));
            tick();
        end
        set_idle();
        idle(3);

        @(negedge clk);
        #1;
        vectors++;
        if (q0.size() != 0 || q1.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain got %0d pending exp 0", q0.size() + q1.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
